// File: rtl/riscv_pkg.sv
// Shared pipeline-control encodings: writeback select, forwarding selects and hazard FSM states.
package riscv_pkg;

    localparam logic [1:0] WB_MEM  = 2'b00;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX operand: MEM result beats WB result, x0 never forwarded.
// Latency: 0 cycles (pure combinational); no backpressure.
module fwd_sel
    import riscv_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] rs,
    input  logic [RAW-1:0] rd_m,
    input  logic           wen_m,
    input  logic [RAW-1:0] rd_w,
    input  logic           wen_w,
    output logic [1:0]     fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (wen_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (wen_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/forwarding (0-cycle combinational) plus memory-wait FSM.
// Backpressure: holds all pipeline registers while data memory is busy; permanent hold after a timeout.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int RAW    = 5,
    parameter int MEM_TO = 16,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RAW-1:0]   rs1D,
    input  logic [RAW-1:0]   rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic [RAW-1:0]   rs1E,
    input  logic [RAW-1:0]   rs2E,
    input  logic [RAW-1:0]   rdE,
    input  logic             RegWEnE,
    input  logic [1:0]       WBSelE,
    input  logic             PCSelE,
    input  logic [RAW-1:0]   rdM,
    input  logic             RegWEnM,
    input  logic             MemReqM,
    input  logic             mem_ready,
    input  logic [RAW-1:0]   rdW,
    input  logic             RegWEnW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = $clog2(MEM_TO + 1);

    hz_state_t     state;
    logic [TW-1:0] to_cnt;
    logic          load_use;
    logic          mem_miss;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    fwd_sel #(.RAW(RAW)) u_fwd_a (
        .rs    (rs1E),
        .rd_m  (rdM),
        .wen_m (RegWEnM),
        .rd_w  (rdW),
        .wen_w (RegWEnW),
        .fwd   (fwd_a)
    );

    fwd_sel #(.RAW(RAW)) u_fwd_b (
        .rs    (rs2E),
        .rd_m  (rdM),
        .wen_m (RegWEnM),
        .rd_w  (rdW),
        .wen_w (RegWEnW),
        .fwd   (fwd_b)
    );

    assign mem_miss = MemReqM && !mem_ready;
    assign load_use = RegWEnE && (WBSelE == WB_MEM) && (rdE != '0) &&
                      ((useRs1D && (rs1D == rdE)) || (useRs2D && (rs2D == rdE)));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FwdA   = FWD_RF;
        FwdB   = FWD_RF;
        if (rst) begin
            FwdA = fwd_a;
            FwdB = fwd_b;
            // A taken branch seen while waiting stays in EX and is acted on once RUN resumes.
            if ((state != RUN) || mem_miss) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSelE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            to_cnt    <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        state  <= MEM_WAIT;
                        to_cnt <= TW'(1);
                    end else if (PCSelE && (flush_cnt != '1)) begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state  <= RUN;
                        to_cnt <= '0;
                    end else if (to_cnt == TW'(MEM_TO)) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
